// File: rtl/spike_window_decoder.sv
// Windowed rate decoder: spike count, first-spike latency, peak state per 2^WINDOW_LOG2-cycle window.
// Result registered one cycle after the last window cycle; an unaccepted result is overwritten and flagged sticky overflow.
module spike_window_decoder #(
  parameter int WINDOW_LOG2 = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  input  logic       abort,
  input  logic       spike_in,
  input  logic [7:0] state_in,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] rate,
  output logic [7:0] first_lat,
  output logic [7:0] peak,
  output logic       overflow
);

  typedef enum logic {S_IDLE, S_COUNT} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WINDOW_LOG2-1:0] r_w;
  logic [7:0]             r_cnt;
  logic [7:0]             r_first;
  logic [7:0]             r_peak;
  logic                   r_seen;
  logic                   r_busy;
  logic                   r_valid;
  logic [7:0]             r_rate;
  logic [7:0]             r_first_lat;
  logic [7:0]             r_peak_out;
  logic                   r_ovf;

  logic                   w_last;
  logic                   w_commit;
  logic                   w_clear;
  logic                   w_accum;
  logic [7:0]             w_w_ext;
  logic [7:0]             w_cnt_nxt;
  logic [7:0]             w_first_nxt;
  logic                   w_seen_nxt;
  logic [7:0]             w_peak_nxt;

  assign w_last  = (r_w == {WINDOW_LOG2{1'b1}});
  assign w_w_ext = 8'(r_w);

  // Window values including this cycle's sample; used for both accumulation and commit.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_first_nxt = r_first;
    w_seen_nxt  = r_seen | spike_in;
    w_peak_nxt  = (state_in > r_peak) ? state_in : r_peak;
    if (spike_in && (r_cnt != 8'hFF)) begin
      w_cnt_nxt = r_cnt + 8'd1;
    end
    if (spike_in && !r_seen) begin
      w_first_nxt = w_w_ext;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_COUNT;
          w_clear     = 1'b1;
        end
      end
      S_COUNT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_commit = 1'b1;
          if (continuous) begin
            w_clear = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accum = (r_state == S_COUNT) && (w_state_nxt == S_COUNT) && !w_clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_w         <= '0;
      r_cnt       <= 8'd0;
      r_first     <= 8'd0;
      r_peak      <= 8'd0;
      r_seen      <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_rate      <= 8'd0;
      r_first_lat <= 8'd0;
      r_peak_out  <= 8'd0;
      r_ovf       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_COUNT);
      // Anything other than a mid-window step (entry, wrap, abort, idle) restarts from zero.
      if (w_accum) begin
        r_w     <= r_w + 1'b1;
        r_cnt   <= w_cnt_nxt;
        r_first <= w_first_nxt;
        r_peak  <= w_peak_nxt;
        r_seen  <= w_seen_nxt;
      end else begin
        r_w     <= '0;
        r_cnt   <= 8'd0;
        r_first <= 8'd0;
        r_peak  <= 8'd0;
        r_seen  <= 1'b0;
      end
      if (w_commit) begin
        r_rate      <= w_cnt_nxt;
        r_first_lat <= w_seen_nxt ? w_first_nxt : 8'hFF;
        r_peak_out  <= w_peak_nxt;
        r_valid     <= 1'b1;
        if (r_valid && !out_ready) begin
          r_ovf <= 1'b1;
        end
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_valid;
  assign rate      = r_rate;
  assign first_lat = r_first_lat;
  assign peak      = r_peak_out;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_spike_window_decoder.sv
// Directed bench for spike_window_decoder: N=8 and N=256 instances share one stimulus set.
module tb_spike_window_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       continuous;
  logic       abort;
  logic       spike_in;
  logic [7:0] state_in;
  logic       out_ready;

  logic       busy8, valid8, ovf8;
  logic [7:0] rate8, first8, peak8;
  logic       busy256, valid256, ovf256;
  logic [7:0] rate256, first256, peak256;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spike_window_decoder #(.WINDOW_LOG2(3)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .spike_in(spike_in), .state_in(state_in), .busy(busy8), .out_valid(valid8),
    .out_ready(out_ready), .rate(rate8), .first_lat(first8), .peak(peak8), .overflow(ovf8)
  );

  spike_window_decoder #(.WINDOW_LOG2(8)) u_dut256 (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
    .spike_in(spike_in), .state_in(state_in), .busy(busy256), .out_valid(valid256),
    .out_ready(out_ready), .rate(rate256), .first_lat(first256), .peak(peak256), .overflow(ovf256)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic s, input logic [7:0] v);
    spike_in = s;
    state_in = v;
    tick();
  endtask

  task automatic check_reset8(input string tag);
    check({tag, "_busy"}, busy8, 0);
    check({tag, "_valid"}, valid8, 0);
    check({tag, "_rate"}, rate8, 0);
    check({tag, "_first"}, first8, 0);
    check({tag, "_peak"}, peak8, 0);
    check({tag, "_ovf"}, ovf8, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
    spike_in = 1'b0; state_in = 8'd0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset8("reset");

    // Window with spikes at 2,5,6 and state = 10*w; a stray start mid-window must not disturb timing.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_busy_w0", busy8, 1);
    for (int w = 0; w < 8; w++) begin
      if (w == 7) begin
        check("t1_valid_early", valid8, 0);
        check("t1_busy_w7", busy8, 1);
      end
      start = (w == 3);
      sample((w == 2) || (w == 5) || (w == 6), 8'(w * 10));
      start = 1'b0;
    end
    check("t1_valid", valid8, 1);
    check("t1_rate", rate8, 3);
    check("t1_first", first8, 2);
    check("t1_peak", peak8, 70);
    check("t1_ovf", ovf8, 0);
    check("t1_busy_done", busy8, 0);
    sample(1'b0, 8'd0);
    check("t1_hold_rate", rate8, 3);
    check("t1_hold_valid", valid8, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_accepted", valid8, 0);

    // No spikes, constant state.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < 8; w++) sample(1'b0, 8'h40);
    check("t2_valid", valid8, 1);
    check("t2_rate", rate8, 0);
    check("t2_first", first8, 8'hFF);
    check("t2_peak", peak8, 8'h40);

    // N=256, spike every cycle: count saturates.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < 256; w++) begin
      if (w == 255) check("t3_busy_last", busy256, 1);
      sample(1'b1, 8'h11);
    end
    check("t3_valid", valid256, 1);
    check("t3_rate", rate256, 8'hFF);
    check("t3_first", first256, 0);
    check("t3_peak", peak256, 8'h11);
    check("t3_busy_done", busy256, 0);

    // Continuous mode, consumer stalled for two windows, then accepts on the third commit.
    do_reset();
    continuous = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < 8; w++) sample(w == 1, 8'd5);
    check("t4_w1_valid", valid8, 1);
    check("t4_w1_rate", rate8, 1);
    check("t4_w1_first", first8, 1);
    check("t4_w1_ovf", ovf8, 0);
    check("t4_w1_busy", busy8, 1);
    for (int w = 0; w < 8; w++) sample((w == 3) || (w == 4), 8'(w));
    check("t4_w2_ovf", ovf8, 1);
    check("t4_w2_rate", rate8, 2);
    check("t4_w2_first", first8, 3);
    check("t4_w2_peak", peak8, 7);
    continuous = 1'b0;
    for (int w = 0; w < 8; w++) begin
      out_ready = (w == 7);
      sample(1'b1, (w == 7) ? 8'h80 : 8'h00);
    end
    check("t4_w3_valid", valid8, 1);
    check("t4_w3_rate", rate8, 8);
    check("t4_w3_first", first8, 0);
    check("t4_w3_peak", peak8, 8'h80);
    check("t4_w3_ovf", ovf8, 1);
    check("t4_w3_busy", busy8, 0);
    tick();
    out_ready = 1'b0;
    check("t4_drain", valid8, 0);

    // Abort at w=4 with a result pending.
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < 8; w++) sample(w == 0, 8'h22);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < 4; w++) sample(1'b1, 8'hF0);
    abort = 1'b1;
    sample(1'b1, 8'hF0);
    abort = 1'b0;
    check("t5_busy", busy8, 0);
    for (int w = 0; w < 8; w++) sample(1'b1, 8'hF0);
    check("t5_valid", valid8, 1);
    check("t5_rate", rate8, 1);
    check("t5_first", first8, 0);
    check("t5_peak", peak8, 8'h22);
    check("t5_ovf", ovf8, 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("t5_start_abort_idle", busy8, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_restart_busy", busy8, 1);
    for (int w = 0; w < 8; w++) sample(w == 7, 8'd9);
    check("t5_new_rate", rate8, 1);
    check("t5_new_first", first8, 7);
    check("t5_new_peak", peak8, 9);
    check("t5_new_ovf", ovf8, 0);

    // Reset mid-window with a result pending.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < 3; w++) sample(1'b1, 8'h33);
    check("t6_pre_valid", valid8, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset8("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_window_decoder.md
# spike_window_decoder

Windowed rate decoder sitting directly downstream of the LIF network's output neuron. It samples the output spike and membrane state over fixed windows of 2^WINDOW_LOG2 cycles. For each completed window it produces the spike count, the first-spike latency and the peak membrane state. Each result is delivered over a valid/ready handshake to the readout/host logic.

## Interface
- WINDOW_LOG2, default 6: window length N = 2^WINDOW_LOG2 cycles; legal range 1..8.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a window; honoured only in IDLE.
- continuous  in  1  sampled at the last window cycle; 1 means re-arm immediately, 0 means return to IDLE.
- abort  in  1  discard the window in progress and go to IDLE; no result is produced.
- spike_in  in  1  output-neuron spike, sampled every COUNT cycle.
- state_in  in  8  output-neuron membrane state, unsigned, sampled every COUNT cycle.
- busy  out  1  high while in COUNT.
- out_valid  out  1  result available; held until accepted.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- rate  out  8  spike count of the window, saturating at 255.
- first_lat  out  8  window index of the first spike; 255 if there were no spikes.
- peak  out  8  maximum state_in sampled in the window.
- overflow  out  1  sticky; set when an unaccepted result is overwritten.

## Operation
- FSM states: IDLE and COUNT.
- IDLE → COUNT when start=1. The first COUNT cycle is window index w=0.
- COUNT → COUNT while w<N-1; w increments each cycle.
- At w=N-1:
  - The result is committed. Values include that cycle's sample.
  - If continuous=1, the next cycle is COUNT with w=0 and the accumulators cleared. There is no gap cycle.
  - Otherwise, go to IDLE.
- Accumulators are cleared on entry to COUNT.
  - cnt += spike_in, saturating at 255. Only N=256 with every cycle spiking reaches saturation.
  - first_lat_acc is loaded with w on the first spike of the window only.
  - peak_acc = max(peak_acc, state_in).
- Commit:
  - rate/first_lat/peak output registers are loaded and out_valid is set.
  - If there were no spikes, first_lat=255 and rate=0. The consumer disambiguates first_lat=255 using rate.
- Handshake:
  - Output registers are stable while out_valid=1 and not accepted.
  - Acceptance clears out_valid on the next edge unless a commit occurs in the same cycle.
- Commit and acceptance in the same cycle: new result loaded, out_valid stays 1, overflow unchanged.
- Commit while out_valid=1 and out_ready=0: new result overwrites the old one, overflow←1.
- overflow is cleared only by rst.
- abort has priority over everything except rst.
  - In COUNT it goes to IDLE and discards the accumulators.
  - If asserted at w=N-1, there is no commit.
  - The output registers and out_valid are untouched.
- start in COUNT is ignored. start and abort in the same IDLE cycle: remain in IDLE.
- spike_in/state_in are ignored in IDLE.

## Timing
- Reset values:
  - state=IDLE, w=0, busy=0.
  - out_valid=0, rate=0, first_lat=0, peak=0, overflow=0.
  - Accumulators 0.
- Latency:
  - start at cycle t → busy=1 from t+1 through t+N.
  - out_valid=1 from t+N+1.
- Continuous mode delivers one result every N cycles. busy stays high across windows.
- All outputs are registered; no combinational path from inputs to outputs.
- rst mid-window returns to the reset state on the next edge and drops any pending result.

## Test plan
- Reset, then WINDOW_LOG2=3 (N=8), start, spike_in=1 at w=2,5,6, state_in=w*10 → out_valid at start+9 with rate=3, first_lat=2, peak=70, overflow=0.
- N=8, no spikes, state_in constant 0x40 → rate=0, first_lat=255, peak=0x40.
- N=256, spike_in=1 every cycle → rate=255 (saturated), first_lat=0.
- continuous=1, out_ready=0 for two windows → second commit sets overflow=1 and the outputs show window 2 values. Then out_ready=1 with a commit in the same cycle → out_valid remains 1 with window 3 values.
- abort at w=4 of an N=8 window with a previous result pending → no new commit, previous result unchanged, busy=0 next cycle. A later start is accepted normally.
- rst asserted mid-window with out_valid=1 → all outputs return to reset values next cycle. start during COUNT is verified to have no effect on window timing.
